// File: rtl/seq_symbol_feeder.sv
// Pulls packed 2-bit symbol words from a valid/ready source and emits one symbol per SYM_PERIOD.
// Optional feature macro REV_COMP_EN: adds rc_mode for LSB-first, complemented emission.
module seq_symbol_feeder #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned SYM_PERIOD = 2,
    parameter int unsigned LEN_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [LEN_W-1:0]  seq_len,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
`ifdef REV_COMP_EN
    input  logic              rc_mode,
`endif
    output logic              in_ready,
    output logic [1:0]        symbol,
    output logic              sym_valid,
    output logic              BC_mode,
    output logic              last,
    output logic              done,
    output logic              busy
);

    localparam int unsigned PairN = WORD_W / 2;
    localparam int unsigned PcW   = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
    localparam int unsigned IdxW  = $clog2(PairN);
    localparam logic [PcW-1:0]  PcLast  = PcW'(SYM_PERIOD - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(PairN - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StEmit, StDone} state_e;

    state_e state_q, state_d;

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [PcW-1:0]    pc_q, pc_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [1:0]        symbol_q, symbol_d;
    logic              sym_valid_q, sym_valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              bc_mode_q, bc_mode_d;
    logic              rc_q;

    logic              take;
    logic              capture;
    logic              emit_now;
    logic              step_now;
    logic [LEN_W-1:0]  rem_after;

    assign take      = (state_q == StIdle) && start;
    assign capture   = (state_q == StLoad) && in_valid;
    assign emit_now  = (state_q == StEmit) && (pc_q == '0);
    assign step_now  = (state_q == StEmit) && (pc_q == PcLast);
    // Post-decrement count, so the run-end test also holds when both actions share a cycle.
    assign rem_after = emit_now ? (rem_q - LEN_W'(1)) : rem_q;

`ifdef REV_COMP_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rc_q <= 1'b0;
        end else if (take) begin
            rc_q <= rc_mode;
        end
    end
`else
    assign rc_q = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (seq_len != '0) ? StLoad : StDone;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (step_now) begin
                    if (rem_after == '0) begin
                        state_d = StDone;
                    end else if (idx_q == IdxLast) begin
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        sreg_d      = sreg_q;
        pc_d        = pc_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        symbol_d    = symbol_q;
        sym_valid_d = 1'b0;
        last_d      = 1'b0;

        if (take) begin
            rem_d = seq_len;
        end
        if (capture) begin
            sreg_d = in_data;
            pc_d   = '0;
            idx_d  = '0;
        end
        if (emit_now) begin
            symbol_d    = rc_q ? ~sreg_q[1:0] : sreg_q[WORD_W-1 -: 2];
            sym_valid_d = 1'b1;
            last_d      = (rem_q == LEN_W'(1));
            rem_d       = rem_after;
        end
        if (state_q == StEmit) begin
            pc_d = step_now ? '0 : (pc_q + PcW'(1));
        end
        if (step_now) begin
            sreg_d = rc_q ? (sreg_q >> 2) : (sreg_q << 2);
            idx_d  = idx_q + IdxW'(1);
        end

        bc_mode_d = (state_d == StLoad) || (state_d == StEmit);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sreg_q      <= '0;
            pc_q        <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            symbol_q    <= 2'b00;
            sym_valid_q <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            bc_mode_q   <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            pc_q        <= pc_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            symbol_q    <= symbol_d;
            sym_valid_q <= sym_valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
            bc_mode_q   <= bc_mode_d;
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign busy      = (state_q != StIdle);
    assign symbol    = symbol_q;
    assign sym_valid = sym_valid_q;
    assign last      = last_q;
    assign done      = done_q;
    assign BC_mode   = bc_mode_q;

endmodule

// File: tb/tb_seq_symbol_feeder.sv
// Directed bench for seq_symbol_feeder: counts, stalls, zero length, reset and ignored restart.
module tb_seq_symbol_feeder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start;
    logic [15:0] seq_len;
    logic [31:0] in_data;
    logic        in_valid;
`ifdef REV_COMP_EN
    logic        rc_mode = 1'b0;
`endif
    logic        in_ready;
    logic [1:0]  symbol;
    logic        sym_valid;
    logic        BC_mode;
    logic        last;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_symbol_feeder #(
        .WORD_W(32),
        .SYM_PERIOD(2),
        .LEN_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .seq_len(seq_len),
        .in_data(in_data),
        .in_valid(in_valid),
`ifdef REV_COMP_EN
        .rc_mode(rc_mode),
`endif
        .in_ready(in_ready),
        .symbol(symbol),
        .sym_valid(sym_valid),
        .BC_mode(BC_mode),
        .last(last),
        .done(done),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Recorder sampled on the falling edge; inputs change 2 units after the rising edge.
    logic [1:0] mon_sym[$];
    int         mon_cyc[$];
    bit         mon_last[$];
    int         mon_done_cyc[$];
    int         mon_hs_cyc[$];
    int         mon_viol = 0;
    int         cyc = 0;
    logic [1:0] prev_sym = 2'b00;

    always @(negedge CLK) begin
        if (sym_valid) begin
            mon_sym.push_back(symbol);
            mon_cyc.push_back(cyc);
            mon_last.push_back(last);
        end
        if (done) mon_done_cyc.push_back(cyc);
        if (in_valid && in_ready) mon_hs_cyc.push_back(cyc);
        if (!RST && !sym_valid && (symbol != prev_sym)) mon_viol <= mon_viol + 1;
        prev_sym <= symbol;
        cyc <= cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic clear_mon();
        mon_sym.delete();
        mon_cyc.delete();
        mon_last.delete();
        mon_done_cyc.delete();
        mon_hs_cyc.delete();
        mon_viol = 0;
    endtask

    task automatic pulse_start(input logic [15:0] len);
        start   = 1'b1;
        seq_len = len;
        step(1);
        start   = 1'b0;
        seq_len = 16'hFFFF;
    endtask

    task automatic send_word(input logic [31:0] d, input int delay);
        int b = 0;
        while (!in_ready && b < 200) begin
            step(1);
            b++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_word_timeout: in_ready=%b required 1", in_ready);
        end
        step(delay);
        in_valid = 1'b1;
        in_data  = d;
        step(1);
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input int budget);
        int b = 0;
        while (!done && b < budget) begin
            step(1);
            b++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done_timeout: done=%b required 1", done);
        end
        step(2);
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        start    = 1'b0;
        seq_len  = 16'd0;
        in_data  = 32'd0;
        in_valid = 1'b0;
        #3;
        checks++;
        if ({symbol, sym_valid, BC_mode, last, done, in_ready, busy} !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {symbol, sym_valid, BC_mode, last, done, in_ready, busy});
        end
        step(2);
        RST = 1'b0;
        step(1);
        checks++;
        if ({BC_mode, busy, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: {BC_mode,busy,in_ready}=%b required 000",
                     {BC_mode, busy, in_ready});
        end
    endtask

    task automatic test_basic();
        logic [1:0] e;
        clear_mon();
        pulse_start(16'd4);
        checks++;
        if ({BC_mode, in_ready, busy} !== 3'b111) begin
            errors++;
            $display("FAIL basic_load: {BC_mode,in_ready,busy}=%b required 111",
                     {BC_mode, in_ready, busy});
        end
        send_word(32'hE400_0000, 0);
        wait_done(50);
        checks++;
        if (mon_sym.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d required 4", mon_sym.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = 2'(3 - i);
                checks++;
                if (mon_sym[i] !== e || mon_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL basic_sym%0d: sym=%0d last=%0d required sym=%0d last=%0d",
                             i, mon_sym[i], mon_last[i], e, (i == 3));
                end
                if (i > 0) begin
                    checks++;
                    if (mon_cyc[i] - mon_cyc[i-1] != 2) begin
                        errors++;
                        $display("FAIL basic_gap%0d: got %0d required 2", i,
                                 mon_cyc[i] - mon_cyc[i-1]);
                    end
                end
            end
            checks++;
            if (mon_hs_cyc.size() != 1 || mon_cyc[0] != mon_hs_cyc[0] + 2) begin
                errors++;
                $display("FAIL basic_latency: handshakes=%0d first_sym_cyc=%0d required 1 and hs+2",
                         mon_hs_cyc.size(), mon_cyc[0]);
            end
            checks++;
            if (mon_done_cyc.size() != 1 || mon_done_cyc[0] != mon_cyc[3] + 1) begin
                errors++;
                $display("FAIL basic_done: pulses=%0d required 1 one cycle after last",
                         mon_done_cyc.size());
            end
        end
        checks++;
        if ({BC_mode, busy, mon_viol != 0} !== 3'b000) begin
            errors++;
            $display("FAIL basic_end: BC_mode=%b busy=%b hold_viol=%0d required 0 0 0",
                     BC_mode, busy, mon_viol);
        end
    endtask

    task automatic test_stall();
        logic [1:0] e;
        int         g;
        clear_mon();
        pulse_start(16'd20);
        send_word(32'hE4E4_E4E4, 0);
        send_word(32'h1B00_0000, 5);
        wait_done(300);
        step(4);
        checks++;
        if (mon_sym.size() != 20) begin
            errors++;
            $display("FAIL stall_count: got %0d required 20", mon_sym.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                e = (i < 16) ? 2'(3 - (i % 4)) : 2'(i - 16);
                checks++;
                if (mon_sym[i] !== e || mon_last[i] !== (i == 19)) begin
                    errors++;
                    $display("FAIL stall_sym%0d: sym=%0d last=%0d required sym=%0d last=%0d",
                             i, mon_sym[i], mon_last[i], e, (i == 19));
                end
                if (i > 0) begin
                    g = (i == 16) ? 8 : 2;
                    checks++;
                    if (mon_cyc[i] - mon_cyc[i-1] != g) begin
                        errors++;
                        $display("FAIL stall_gap%0d: got %0d required %0d", i,
                                 mon_cyc[i] - mon_cyc[i-1], g);
                    end
                end
            end
        end
        checks++;
        if (mon_hs_cyc.size() != 2 || mon_done_cyc.size() != 1) begin
            errors++;
            $display("FAIL stall_handshakes: hs=%0d done=%0d required 2 1",
                     mon_hs_cyc.size(), mon_done_cyc.size());
        end
        checks++;
        if ({in_ready, busy, mon_viol != 0} !== 3'b000) begin
            errors++;
            $display("FAIL stall_end: in_ready=%b busy=%b hold_viol=%0d required 0 0 0",
                     in_ready, busy, mon_viol);
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        pulse_start(16'd0);
        checks++;
        if ({done, in_ready, BC_mode, sym_valid, busy} !== 5'b10001) begin
            errors++;
            $display("FAIL zero_done: {done,in_ready,BC_mode,sym_valid,busy}=%b required 10001",
                     {done, in_ready, BC_mode, sym_valid, busy});
        end
        step(1);
        checks++;
        if ({done, busy, BC_mode} !== 3'b000 || mon_sym.size() != 0) begin
            errors++;
            $display("FAIL zero_after: {done,busy,BC_mode}=%b syms=%0d required 000 0",
                     {done, busy, BC_mode}, mon_sym.size());
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        int b = 0;
        clear_mon();
        pulse_start(16'd16);
        send_word(32'hE4E4_E4E4, 0);
        while (n < 3 && b < 100) begin
            if (sym_valid) n++;
            if (n < 3) step(1);
            b++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL rstmid_wait: saw %0d symbols required 3", n);
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({symbol, sym_valid, BC_mode, last, done, in_ready, busy} !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b required 00000000",
                     {symbol, sym_valid, BC_mode, last, done, in_ready, busy});
        end
        step(1);
        RST = 1'b0;
        step(1);
        clear_mon();
        pulse_start(16'd16);
        send_word(32'hE4E4_E4E4, 0);
        wait_done(100);
        checks++;
        if (mon_sym.size() != 16 || mon_hs_cyc.size() != 1) begin
            errors++;
            $display("FAIL rstmid_replay_count: syms=%0d hs=%0d required 16 1",
                     mon_sym.size(), mon_hs_cyc.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (mon_sym[i] !== 2'(3 - (i % 4)) || mon_last[i] !== (i == 15)) begin
                    errors++;
                    $display("FAIL rstmid_sym%0d: sym=%0d last=%0d required sym=%0d last=%0d",
                             i, mon_sym[i], mon_last[i], 3 - (i % 4), (i == 15));
                end
            end
        end
    endtask

    task automatic test_restart_ignored();
        clear_mon();
        pulse_start(16'd16);
        send_word(32'h1B1B_1B1B, 0);
        step(5);
        start   = 1'b1;
        seq_len = 16'd2;
        step(1);
        start   = 1'b0;
        wait_done(100);
        checks++;
        if (mon_sym.size() != 16 || mon_done_cyc.size() != 1 || mon_hs_cyc.size() != 1) begin
            errors++;
            $display("FAIL restart_count: syms=%0d done=%0d hs=%0d required 16 1 1",
                     mon_sym.size(), mon_done_cyc.size(), mon_hs_cyc.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (mon_sym[i] !== 2'(i % 4) || mon_last[i] !== (i == 15)) begin
                    errors++;
                    $display("FAIL restart_sym%0d: sym=%0d last=%0d required sym=%0d last=%0d",
                             i, mon_sym[i], mon_last[i], i % 4, (i == 15));
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_end: busy=%b required 0", busy);
        end
    endtask

`ifdef REV_COMP_EN
    task automatic test_rev_comp();
        logic [1:0] e;
        clear_mon();
        rc_mode = 1'b1;
        pulse_start(16'd16);
        rc_mode = 1'b0;
        send_word(32'h0000_00E4, 0);
        wait_done(100);
        checks++;
        if (mon_sym.size() != 16) begin
            errors++;
            $display("FAIL rc_count: got %0d required 16", mon_sym.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = (i < 4) ? 2'(3 - i) : 2'd3;
                checks++;
                if (mon_sym[i] !== e) begin
                    errors++;
                    $display("FAIL rc_sym%0d: got %0d required %0d", i, mon_sym[i], e);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_reset_mid_run();
        test_restart_ignored();
`ifdef REV_COMP_EN
        test_rev_comp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
